// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, reads one 32-bit instruction as four
// little-endian bytes through the byte-wide memory arbiter, and presents it
// with a valid flag to the IF/ID register until it is consumed or redirected.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic [7:0]  mem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  ic_q, ic_d;
  logic [2:0]  rc_q, rc_d;
  logic        pending_q, pending_d;
  // Only bytes 0..2 need storage; byte 3 goes straight into the output word.
  logic [23:0] asm_q, asm_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;

  // Request side: issue the next byte address while bytes remain in FETCH.
  always_comb begin
    mem_req_o  = (state_q == FETCH) && (ic_q < 3'd4) && !rst;
    mem_addr_o = pc_q + {29'd0, ic_q};
  end

  assign pc_o         = pc_out_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = valid_q;

  // Next-state logic: redirect first, then byte capture / consumption.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ic_d      = ic_q;
    rc_d      = rc_q;
    asm_d     = asm_q;
    inst_d    = inst_q;
    pc_out_d  = pc_out_q;
    valid_d   = valid_q;
    // A byte granted on a redirect edge belongs to the old stream; drop it.
    pending_d = mem_req_o && mem_gnt_i && !branch_flag_i;

    if (branch_flag_i) begin
      pc_d    = branch_target_address_i;
      ic_d    = 3'd0;
      rc_d    = 3'd0;
      valid_d = 1'b0;
      state_d = FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (mem_req_o && mem_gnt_i) begin
            ic_d = ic_q + 3'd1;
          end else begin
            ic_d = ic_q;
          end
          if (pending_q) begin
            if (rc_q == 3'd3) begin
              inst_d   = {mem_data_i, asm_q};
              pc_out_d = pc_q;
              valid_d  = 1'b1;
              state_d  = HOLD;
              ic_d     = 3'd0;
              rc_d     = 3'd0;
            end else begin
              case (rc_q[1:0])
                2'd0:    asm_d[7:0]   = mem_data_i;
                2'd1:    asm_d[15:8]  = mem_data_i;
                2'd2:    asm_d[23:16] = mem_data_i;
                default: asm_d        = asm_q;
              endcase
              rc_d = rc_q + 3'd1;
            end
          end else begin
            rc_d = rc_q;
          end
        end
        HOLD: begin
          if (!stall_i) begin
            pc_d    = pc_q + 32'd4;
            valid_d = 1'b0;
            state_d = FETCH;
          end else begin
            state_d = HOLD;
          end
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

  // State registers with synchronous reset; reset abandons any byte in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      ic_q      <= 3'd0;
      rc_q      <= 3'd0;
      pending_q <= 1'b0;
      asm_q     <= 24'd0;
      inst_q    <= 32'd0;
      pc_out_q  <= RESET_PC;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ic_q      <= ic_d;
      rc_q      <= rc_d;
      pending_q <= pending_d;
      asm_q     <= asm_d;
      inst_q    <= inst_d;
      pc_out_q  <= pc_out_d;
      valid_q   <= valid_d;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios from the fetch timing
// rules plus a long randomized run against a transaction-level memory model.
module tb_if_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic [7:0]  mem_data_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem [0:511];

  // Reference model: PC, queue of byte addresses still to request, bytes back.
  logic [31:0] m_pc, m_pc_o, m_inst;
  bit          m_valid, m_inflight;
  int          m_got;
  logic [31:0] m_q[$];

  if_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .branch_flag_i(branch_flag_i),
    .branch_target_address_i(branch_target_address_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_data_i(mem_data_i), .pc_o(pc_o), .inst_o(inst_o),
    .inst_valid_o(inst_valid_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mb(input logic [31:0] a);
    return mem[a[8:0]];
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {mb(a + 32'd3), mb(a + 32'd2), mb(a + 32'd1), mb(a)};
  endfunction

  function automatic logic e_req();
    return !rst && !m_valid && (m_q.size() > 0);
  endfunction

  function automatic logic [31:0] e_addr();
    return (m_q.size() > 0) ? m_q[0] : 32'h0;
  endfunction

  function automatic void refill();
    m_q.delete();
    for (int k = 0; k < 4; k++) m_q.push_back(m_pc + 32'(k));
    m_got = 0;
  endfunction

  function automatic void model_update(input bit req);
    bit grab, old_inf;
    if (rst) begin
      m_pc = RESET_PC; m_pc_o = RESET_PC; m_inst = 32'h0;
      m_valid = 1'b0; m_inflight = 1'b0; refill();
    end else if (branch_flag_i) begin
      m_pc = branch_target_address_i; m_valid = 1'b0; m_inflight = 1'b0; refill();
    end else begin
      old_inf = m_inflight;
      grab    = req && mem_gnt_i;
      if (grab) void'(m_q.pop_front());
      m_inflight = grab;
      if (m_valid && !stall_i) begin
        m_valid = 1'b0; m_pc = m_pc + 32'd4; refill();
      end else if (old_inf) begin
        m_got++;
        if (m_got == 4) begin
          m_valid = 1'b1; m_pc_o = m_pc; m_inst = word_at(m_pc);
        end
      end
    end
  endfunction

  // Advance one clock: update the model and return the granted byte next cycle.
  task automatic tick();
    bit          req_m, g;
    logic [31:0] a;
    req_m = e_req();
    g     = mem_req_o && mem_gnt_i;
    a     = mem_addr_o;
    @(posedge clk);
    model_update(req_m);
    #1;
    mem_data_i = g ? mb(a) : 8'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1; stall_i = 1'b0; branch_flag_i = 1'b0; mem_gnt_i = 1'b1;
    branch_target_address_i = 32'h0;
    #1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall_i = 1'b0; branch_flag_i = 1'b0; mem_gnt_i = 1'b1;
    branch_target_address_i = 32'h0; mem_data_i = 8'h0;
    #1;
    n_checks++;
    if (mem_req_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_req got=%b exp=0", mem_req_o);
    end
    tick(); tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if ({inst_valid_o, inst_o, pc_o, mem_req_o, mem_addr_o} !== {1'b0, 32'h0, RESET_PC, 1'b1, RESET_PC}) begin
      n_fail++;
      $display("FAIL reset_state got v=%b i=%h pc=%h r=%b a=%h exp v=0 i=0 pc=%h r=1 a=%h",
               inst_valid_o, inst_o, pc_o, mem_req_o, mem_addr_o, RESET_PC, RESET_PC);
    end
  endtask

  task automatic test_reset_fetch();
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      #1;
      n_checks++;
      if ({mem_req_o, e_req() ? mem_addr_o : 32'h0, inst_valid_o, inst_o, pc_o} !==
          {e_req(), e_req() ? e_addr() : 32'h0, m_valid, m_inst, m_pc_o}) begin
        n_fail++; $display("FAIL rf_model c=%0d addr=%h v=%b inst=%h pc=%h", c, mem_addr_o, inst_valid_o, inst_o, pc_o);
      end
      if (c <= 3) begin
        n_checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'(c)) begin
          n_fail++; $display("FAIL rf_addr c=%0d got=%b/%h exp=1/%h", c, mem_req_o, mem_addr_o, 32'(c));
        end
      end
      if (c == 4) begin
        n_checks++;
        if (inst_valid_o !== 1'b0) begin
          n_fail++; $display("FAIL rf_early_valid got=%b exp=0", inst_valid_o);
        end
      end
      if (c == 5) begin
        n_checks++;
        if ({inst_valid_o, inst_o, pc_o} !== {1'b1, 32'h00500513, 32'h0}) begin
          n_fail++; $display("FAIL rf_word got=%b/%h/%h exp=1/00500513/00000000", inst_valid_o, inst_o, pc_o);
        end
      end
      if (c == 6) begin
        n_checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h4) begin
          n_fail++; $display("FAIL rf_next got=%b/%h exp=1/00000004", mem_req_o, mem_addr_o);
        end
      end
      tick();
    end
  endtask

  task automatic test_grant_gaps();
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      mem_gnt_i = !(c == 1 || c == 2);
      #1;
      n_checks++;
      if ({mem_req_o, e_req() ? mem_addr_o : 32'h0, inst_valid_o, inst_o, pc_o} !==
          {e_req(), e_req() ? e_addr() : 32'h0, m_valid, m_inst, m_pc_o}) begin
        n_fail++; $display("FAIL gg_model c=%0d addr=%h v=%b inst=%h", c, mem_addr_o, inst_valid_o, inst_o);
      end
      if (c >= 1 && c <= 3) begin
        n_checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h1) begin
          n_fail++; $display("FAIL gg_hold_addr c=%0d got=%b/%h exp=1/00000001", c, mem_req_o, mem_addr_o);
        end
      end
      if (c == 6 || c == 7) begin
        n_checks++;
        if (inst_valid_o !== (c == 7) || (c == 7 && inst_o !== 32'h00500513)) begin
          n_fail++; $display("FAIL gg_valid c=%0d got=%b/%h exp=%b/00500513", c, inst_valid_o, inst_o, c == 7);
        end
      end
      tick();
    end
    mem_gnt_i = 1'b1;
  endtask

  task automatic test_stall_hold();
    do_reset();
    for (int c = 0; c <= 9; c++) begin
      stall_i = (c >= 5 && c <= 7);
      #1;
      n_checks++;
      if ({mem_req_o, e_req() ? mem_addr_o : 32'h0, inst_valid_o, inst_o, pc_o} !==
          {e_req(), e_req() ? e_addr() : 32'h0, m_valid, m_inst, m_pc_o}) begin
        n_fail++; $display("FAIL st_model c=%0d addr=%h v=%b inst=%h", c, mem_addr_o, inst_valid_o, inst_o);
      end
      if (c >= 5 && c <= 8) begin
        n_checks++;
        if ({inst_valid_o, inst_o, pc_o, mem_req_o} !== {1'b1, 32'h00500513, 32'h0, 1'b0}) begin
          n_fail++; $display("FAIL st_held c=%0d got=%b/%h/%h/%b exp=1/00500513/00000000/0", c, inst_valid_o, inst_o, pc_o, mem_req_o);
        end
      end
      if (c == 9) begin
        n_checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h4) begin
          n_fail++; $display("FAIL st_advance got=%b/%h exp=1/00000004", mem_req_o, mem_addr_o);
        end
      end
      tick();
    end
    stall_i = 1'b0;
  endtask

  task automatic test_redirect_mid();
    do_reset();
    for (int c = 0; c <= 9; c++) begin
      branch_flag_i = (c == 2);
      branch_target_address_i = 32'h100;
      #1;
      n_checks++;
      if ({mem_req_o, e_req() ? mem_addr_o : 32'h0, inst_valid_o, inst_o, pc_o} !==
          {e_req(), e_req() ? e_addr() : 32'h0, m_valid, m_inst, m_pc_o}) begin
        n_fail++; $display("FAIL rm_model c=%0d addr=%h v=%b inst=%h pc=%h", c, mem_addr_o, inst_valid_o, inst_o, pc_o);
      end
      if (c >= 3 && c <= 6) begin
        n_checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100 + 32'(c - 3)) begin
          n_fail++; $display("FAIL rm_addr c=%0d got=%b/%h exp=1/%h", c, mem_req_o, mem_addr_o, 32'h100 + 32'(c - 3));
        end
      end
      if (c < 8) begin
        n_checks++;
        if (inst_valid_o !== 1'b0) begin
          n_fail++; $display("FAIL rm_stale_valid c=%0d got=%b exp=0", c, inst_valid_o);
        end
      end
      if (c == 8) begin
        n_checks++;
        if ({inst_valid_o, pc_o, inst_o} !== {1'b1, 32'h100, word_at(32'h100)}) begin
          n_fail++; $display("FAIL rm_word got=%b/%h/%h exp=1/00000100/%h", inst_valid_o, pc_o, inst_o, word_at(32'h100));
        end
      end
      tick();
    end
    branch_flag_i = 1'b0;
  endtask

  task automatic test_redirect_hold_stall();
    do_reset();
    for (int c = 0; c <= 9; c++) begin
      stall_i = (c >= 5);
      branch_flag_i = (c == 6);
      branch_target_address_i = 32'h40;
      #1;
      n_checks++;
      if ({mem_req_o, e_req() ? mem_addr_o : 32'h0, inst_valid_o, inst_o, pc_o} !==
          {e_req(), e_req() ? e_addr() : 32'h0, m_valid, m_inst, m_pc_o}) begin
        n_fail++; $display("FAIL rh_model c=%0d addr=%h v=%b inst=%h", c, mem_addr_o, inst_valid_o, inst_o);
      end
      if (c == 7 || c == 8) begin
        n_checks++;
        if ({inst_valid_o, mem_req_o, mem_addr_o} !== {1'b0, 1'b1, 32'h40 + 32'(c - 7)}) begin
          n_fail++; $display("FAIL rh_restart c=%0d got=%b/%b/%h exp=0/1/%h", c, inst_valid_o, mem_req_o, mem_addr_o, 32'h40 + 32'(c - 7));
        end
      end
      tick();
    end
    stall_i = 1'b0; branch_flag_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c <= 15; c++) begin
      branch_flag_i = (c == 0);
      branch_target_address_i = 32'h100;
      rst = (c == 9);
      #1;
      if (c != 9) begin
        n_checks++;
        if ({mem_req_o, e_req() ? mem_addr_o : 32'h0, inst_valid_o, inst_o, pc_o} !==
            {e_req(), e_req() ? e_addr() : 32'h0, m_valid, m_inst, m_pc_o}) begin
          n_fail++; $display("FAIL rr_model c=%0d addr=%h v=%b inst=%h pc=%h", c, mem_addr_o, inst_valid_o, inst_o, pc_o);
        end
      end
      if (c == 9) begin
        n_checks++;
        if (mem_req_o !== 1'b0) begin
          n_fail++; $display("FAIL rr_req_in_reset got=%b exp=0", mem_req_o);
        end
      end
      if (c == 10) begin
        n_checks++;
        if ({inst_valid_o, inst_o, pc_o, mem_req_o, mem_addr_o} !== {1'b0, 32'h0, RESET_PC, 1'b1, RESET_PC}) begin
          n_fail++; $display("FAIL rr_state got=%b/%h/%h/%b/%h exp=0/0/%h/1/%h", inst_valid_o, inst_o, pc_o, mem_req_o, mem_addr_o, RESET_PC, RESET_PC);
        end
      end
      if (c == 15) begin
        n_checks++;
        if ({inst_valid_o, inst_o, pc_o} !== {1'b1, 32'h00500513, RESET_PC}) begin
          n_fail++; $display("FAIL rr_refetch got=%b/%h/%h exp=1/00500513/%h", inst_valid_o, inst_o, pc_o, RESET_PC);
        end
      end
      tick();
    end
    branch_flag_i = 1'b0; rst = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst           = ($urandom_range(99) == 0);
      branch_flag_i = ($urandom_range(19) == 0);
      branch_target_address_i = ($urandom_range(3) == 0) ?
                                (32'hFFFF_FFFC + 32'($urandom_range(3))) : ($urandom & 32'h0000_01FF);
      mem_gnt_i     = ($urandom_range(9) < 7);
      stall_i       = ($urandom_range(2) == 0);
      #1;
      n_checks++;
      if ({mem_req_o, e_req() ? mem_addr_o : 32'h0, inst_valid_o, inst_o, pc_o} !==
          {e_req(), e_req() ? e_addr() : 32'h0, m_valid, m_inst, m_pc_o}) begin
        n_fail++;
        $display("FAIL rnd_model c=%0d got r=%b a=%h v=%b i=%h pc=%h exp r=%b a=%h v=%b i=%h pc=%h",
                 c, mem_req_o, mem_addr_o, inst_valid_o, inst_o, pc_o,
                 e_req(), e_addr(), m_valid, m_inst, m_pc_o);
      end
      tick();
    end
    rst = 1'b0; branch_flag_i = 1'b0; stall_i = 1'b0; mem_gnt_i = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h50; mem[3] = 8'h00;
    m_pc = RESET_PC; m_pc_o = RESET_PC; m_inst = 32'h0;
    m_valid = 1'b0; m_inflight = 1'b0; refill();
    test_reset();
    test_reset_fetch();
    test_grant_gaps();
    test_stall_hold();
    test_redirect_mid();
    test_redirect_hold_stall();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
